// File: rtl/multi_cycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_control_unit_pkg
//  Purpose  : Shared encodings for the multi-cycle MIPS control unit: opcode,
//             funct and ALU codes, datapath mux selects and FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package multi_cycle_control_unit_pkg;

    // Field widths
    localparam int c_opcode_w = 6;
    localparam int c_funct_w  = 6;
    localparam int c_alu_op_w = 3;
    localparam int c_state_w  = 4;

    // Primary opcodes
    localparam logic [c_opcode_w-1:0] c_op_rtype = 6'h00;
    localparam logic [c_opcode_w-1:0] c_op_j     = 6'h02;
    localparam logic [c_opcode_w-1:0] c_op_beq   = 6'h04;
    localparam logic [c_opcode_w-1:0] c_op_addi  = 6'h08;
    localparam logic [c_opcode_w-1:0] c_op_ori   = 6'h0D;
    localparam logic [c_opcode_w-1:0] c_op_lw    = 6'h23;
    localparam logic [c_opcode_w-1:0] c_op_sw    = 6'h2B;

    // R-type funct codes
    localparam logic [c_funct_w-1:0] c_funct_add = 6'h20;
    localparam logic [c_funct_w-1:0] c_funct_sub = 6'h22;
    localparam logic [c_funct_w-1:0] c_funct_and = 6'h24;
    localparam logic [c_funct_w-1:0] c_funct_or  = 6'h25;

    // ALU operation codes; the default is an idle code no instruction uses
    localparam logic [c_alu_op_w-1:0] c_alu_and     = 3'b000;
    localparam logic [c_alu_op_w-1:0] c_alu_or      = 3'b001;
    localparam logic [c_alu_op_w-1:0] c_alu_add     = 3'b010;
    localparam logic [c_alu_op_w-1:0] c_alu_default = 3'b011;
    localparam logic [c_alu_op_w-1:0] c_alu_sub     = 3'b110;

    // ALU B-operand select
    localparam logic [1:0] c_alu_src_b_reg      = 2'b00;
    localparam logic [1:0] c_alu_src_b_four     = 2'b01;
    localparam logic [1:0] c_alu_src_b_imm      = 2'b10;
    localparam logic [1:0] c_alu_src_b_imm_shl2 = 2'b11;

    // PC source select
    localparam logic [1:0] c_pc_src_alu    = 2'b00;
    localparam logic [1:0] c_pc_src_aluout = 2'b01;
    localparam logic [1:0] c_pc_src_jump   = 2'b10;

    // Controller states
    typedef enum logic [c_state_w-1:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_R_EXEC   = 4'd2,
        ST_R_WB     = 4'd3,
        ST_I_EXEC   = 4'd4,
        ST_I_WB     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_ILLEGAL  = 4'd12
    } state_e;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_control_unit_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational R-type funct to ALU operation decode, with a flag
//             marking funct codes the core supports.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
    import multi_cycle_control_unit_pkg::*;
(
    input  logic [c_funct_w-1:0]  i_funct,
    output logic [c_alu_op_w-1:0] o_alu_op,
    output logic                  o_funct_valid
);

    // Map funct to ALU op; unsupported codes give the idle op and valid=0
    always_comb begin
        o_alu_op      = c_alu_default;
        o_funct_valid = 1'b0;
        case (i_funct)
            c_funct_add: begin o_alu_op = c_alu_add; o_funct_valid = 1'b1; end
            c_funct_sub: begin o_alu_op = c_alu_sub; o_funct_valid = 1'b1; end
            c_funct_and: begin o_alu_op = c_alu_and; o_funct_valid = 1'b1; end
            c_funct_or:  begin o_alu_op = c_alu_or;  o_funct_valid = 1'b1; end
            default: begin
                o_alu_op      = c_alu_default;
                o_funct_valid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_control_unit
//  Purpose  : Control FSM for the multi-cycle MIPS datapath. Steps each
//             instruction through fetch/decode/execute/memory/write-back and
//             drives the datapath enables, with an optional memory-ready stall.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_control_unit
    import multi_cycle_control_unit_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,  // 1: memory states wait for mem_ready
    parameter int TRAP_ILLEGAL  = 1,  // 1: bad opcode/funct halts in ILLEGAL
    parameter int STATE_W       = 4   // debug state width, at least 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [c_opcode_w-1:0] opcode,
    input  logic [c_funct_w-1:0]  funct,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  mem_to_reg,
    output logic                  reg_dst,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_source,
    output logic [c_alu_op_w-1:0] alu_op,
    output logic                  instr_done,
    output logic                  illegal_op,
    output logic [STATE_W-1:0]    state_o
);

    state_e                  state_q;
    state_e                  state_d;
    logic                    w_mem_done;
    state_e                  w_bad_target;
    logic [c_alu_op_w-1:0]   w_r_alu_op;
    logic                    w_funct_valid;

    // Without the handshake every memory access completes in its first cycle
    assign w_mem_done   = (MEM_HANDSHAKE == 0) || mem_ready;
    // Where an unsupported instruction goes: halt, or skip as a NOP
    assign w_bad_target = (TRAP_ILLEGAL != 0) ? ST_ILLEGAL : ST_FETCH;

    alu_decoder u_alu_decoder (
        .i_funct       (funct),
        .o_alu_op      (w_r_alu_op),
        .o_funct_valid (w_funct_valid)
    );

    // State register; reset wins from any state, including a stalled access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (w_mem_done) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    c_op_rtype:        state_d = ST_R_EXEC;
                    c_op_addi, c_op_ori: state_d = ST_I_EXEC;
                    c_op_lw, c_op_sw:  state_d = ST_MEM_ADDR;
                    c_op_beq:          state_d = ST_BRANCH;
                    c_op_j:            state_d = ST_JUMP;
                    default:           state_d = w_bad_target;
                endcase
            end
            ST_R_EXEC:   state_d = w_funct_valid ? ST_R_WB : w_bad_target;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_MEM_ADDR: begin
                // Opcode was already qualified in DECODE; guard against a
                // changed IR anyway so the FSM never wanders
                if (opcode == c_op_lw) begin
                    state_d = ST_MEM_RD;
                end else if (opcode == c_op_sw) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d = w_bad_target;
                end
            end
            ST_MEM_RD: begin
                if (w_mem_done) begin
                    state_d = ST_MEM_WB;
                end
            end
            ST_MEM_WR: begin
                if (w_mem_done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_R_WB, ST_I_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_ILLEGAL:  state_d = ST_ILLEGAL;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Output decode from the current state; defaults first
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = c_alu_src_b_reg;
        pc_source     = c_pc_src_alu;
        alu_op        = c_alu_default;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // PC+4 is computed every fetch cycle, but IR and PC only
                // load in the cycle the instruction word is actually there
                mem_read  = 1'b1;
                iord      = 1'b0;
                ir_write  = w_mem_done;
                pc_write  = w_mem_done;
                alu_src_a = 1'b0;
                alu_src_b = c_alu_src_b_four;
                alu_op    = c_alu_add;
                pc_source = c_pc_src_alu;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_a = 1'b0;
                alu_src_b = c_alu_src_b_imm_shl2;
                alu_op    = c_alu_add;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = c_alu_src_b_reg;
                alu_op    = w_r_alu_op;
            end
            ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
                instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = c_alu_src_b_imm;
                alu_op    = (opcode == c_op_ori) ? c_alu_or : c_alu_add;
            end
            ST_I_WB: begin
                reg_dst    = 1'b0;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_alu_src_b_imm;
                alu_op    = c_alu_add;
            end
            ST_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                reg_dst    = 1'b0;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                // A store retires in the cycle memory accepts it
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = w_mem_done;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = c_alu_src_b_reg;
                alu_op        = c_alu_sub;
                pc_source     = c_pc_src_aluout;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
            end
            ST_JUMP: begin
                pc_source  = c_pc_src_jump;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            ST_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: begin
                illegal_op = 1'b0;
            end
        endcase
    end

    // Debug view of the state, zero-extended to the requested width
    assign state_o = STATE_W'(state_q);

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_cycle_control_unit
//  Purpose  : Self-checking bench for the multi-cycle control unit with the
//             memory handshake and illegal-op trap enabled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_control_unit;
    import multi_cycle_control_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic        instr_done, illegal_op;
    logic [3:0]  state_o;

    always #5 clk = ~clk;

    multi_cycle_control_unit #(
        .MEM_HANDSHAKE (1),
        .TRAP_ILLEGAL  (1),
        .STATE_W       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state_o       (state_o)
    );

    // Observed control word, packed in a fixed order for compact comparison
    wire [18:0] ctl_obs = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                           alu_src_b, pc_source, alu_op, instr_done, illegal_op};

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       rn;
    } stim_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] ctl;
    } exp_t;

    stim_t stq[$];
    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;

    // Expected control word for a state, from the controller's output table
    function automatic logic [18:0] model(state_e st, logic [5:0] op,
                                          logic [5:0] fn, logic rdy);
        logic       pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, dn, il;
        logic [1:0] sbs, ps;
        logic [2:0] ao;
        pw = 0; pwc = 0; io = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rd = 0;
        rw = 0; sa = 0; dn = 0; il = 0; sbs = 2'b00; ps = 2'b00;
        ao = c_alu_default;
        case (st)
            ST_FETCH:    begin mr = 1; irw = rdy; pw = rdy; sbs = 2'b01; ao = c_alu_add; end
            ST_DECODE:   begin sbs = 2'b11; ao = c_alu_add; end
            ST_R_EXEC: begin
                sa = 1;
                case (fn)
                    c_funct_add: ao = c_alu_add;
                    c_funct_sub: ao = c_alu_sub;
                    c_funct_and: ao = c_alu_and;
                    c_funct_or:  ao = c_alu_or;
                    default:     ao = c_alu_default;
                endcase
            end
            ST_R_WB:     begin rd = 1; rw = 1; dn = 1; end
            ST_I_EXEC:   begin sa = 1; sbs = 2'b10; ao = (op == c_op_ori) ? c_alu_or : c_alu_add; end
            ST_I_WB:     begin rw = 1; dn = 1; end
            ST_MEM_ADDR: begin sa = 1; sbs = 2'b10; ao = c_alu_add; end
            ST_MEM_RD:   begin io = 1; mr = 1; end
            ST_MEM_WB:   begin m2r = 1; rw = 1; dn = 1; end
            ST_MEM_WR:   begin io = 1; mw = 1; dn = rdy; end
            ST_BRANCH:   begin sa = 1; ao = c_alu_sub; ps = 2'b01; pwc = 1; dn = 1; end
            ST_JUMP:     begin ps = 2'b10; pw = 1; dn = 1; end
            ST_ILLEGAL:  begin il = 1; end
            default:     begin il = 0; end
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sbs, ps, ao, dn, il};
    endfunction

    // Queue one cycle of stimulus together with the state/outputs it must show
    task automatic plan(input state_e st, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic rn);
        stq.push_back('{op, fn, rdy, rn});
        sb.push_back('{st, model(st, op, fn, rdy)});
    endtask

    // Apply the next stimulus after the falling edge and hand back its expectation
    task automatic step(output exp_t e);
        stim_t s;
        @(negedge clk);
        s = stq.pop_front();
        opcode    = s.op;
        funct     = s.fn;
        mem_ready = s.rdy;
        rst_n     = s.rn;
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t e;
        int   n = 0;
        rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        plan(ST_FETCH, 6'h00, 6'h00, 1'b0, 1'b1);
        plan(ST_FETCH, 6'h00, 6'h00, 1'b1, 1'b0);
        plan(ST_FETCH, 6'h00, 6'h00, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL reset c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    task automatic test_rtype();
        exp_t       e;
        int         n = 0;
        logic [5:0] fl[4];
        fl[0] = c_funct_add; fl[1] = c_funct_sub; fl[2] = c_funct_and; fl[3] = c_funct_or;
        for (int k = 0; k < 4; k++) begin
            plan(ST_FETCH,  c_op_rtype, fl[k], 1'b1, 1'b1);
            plan(ST_DECODE, c_op_rtype, fl[k], 1'b0, 1'b1);
            plan(ST_R_EXEC, c_op_rtype, fl[k], 1'b1, 1'b1);
            plan(ST_R_WB,   c_op_rtype, fl[k], 1'b0, 1'b1);
        end
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL rtype c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    task automatic test_itype();
        exp_t e;
        int   n = 0;
        plan(ST_FETCH,  c_op_addi, 6'h11, 1'b1, 1'b1);
        plan(ST_DECODE, c_op_addi, 6'h11, 1'b1, 1'b1);
        plan(ST_I_EXEC, c_op_addi, 6'h11, 1'b0, 1'b1);
        plan(ST_I_WB,   c_op_addi, 6'h11, 1'b1, 1'b1);
        plan(ST_FETCH,  c_op_ori,  6'h3A, 1'b1, 1'b1);
        plan(ST_DECODE, c_op_ori,  6'h3A, 1'b0, 1'b1);
        plan(ST_I_EXEC, c_op_ori,  6'h3A, 1'b0, 1'b1);
        plan(ST_I_WB,   c_op_ori,  6'h3A, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL itype c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    task automatic test_lw_wait();
        exp_t e;
        int   n = 0;
        plan(ST_FETCH,    c_op_lw, 6'h00, 1'b1, 1'b1);
        plan(ST_DECODE,   c_op_lw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_ADDR, c_op_lw, 6'h00, 1'b1, 1'b1);
        plan(ST_MEM_RD,   c_op_lw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_RD,   c_op_lw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_RD,   c_op_lw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_RD,   c_op_lw, 6'h00, 1'b1, 1'b1);
        plan(ST_MEM_WB,   c_op_lw, 6'h00, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL lw_wait c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    task automatic test_sw();
        exp_t e;
        int   n = 0;
        plan(ST_FETCH,    c_op_sw, 6'h00, 1'b1, 1'b1);
        plan(ST_DECODE,   c_op_sw, 6'h00, 1'b1, 1'b1);
        plan(ST_MEM_ADDR, c_op_sw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_WR,   c_op_sw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_WR,   c_op_sw, 6'h00, 1'b1, 1'b1);
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL sw c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    task automatic test_branch_jump();
        exp_t e;
        int   n = 0;
        plan(ST_FETCH,  c_op_beq, 6'h00, 1'b1, 1'b1);
        plan(ST_DECODE, c_op_beq, 6'h00, 1'b0, 1'b1);
        plan(ST_BRANCH, c_op_beq, 6'h00, 1'b1, 1'b1);
        plan(ST_FETCH,  c_op_j,   6'h00, 1'b1, 1'b1);
        plan(ST_DECODE, c_op_j,   6'h00, 1'b1, 1'b1);
        plan(ST_JUMP,   c_op_j,   6'h00, 1'b1, 1'b1);
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL branch_jump c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n = 0;
        plan(ST_FETCH,  c_op_rtype, c_funct_sub, 1'b0, 1'b1);
        plan(ST_FETCH,  c_op_rtype, c_funct_sub, 1'b1, 1'b1);
        plan(ST_DECODE, c_op_rtype, c_funct_sub, 1'b1, 1'b1);
        plan(ST_R_EXEC, c_op_rtype, c_funct_sub, 1'b1, 1'b1);
        plan(ST_R_WB,   c_op_rtype, c_funct_sub, 1'b1, 1'b1);
        plan(ST_FETCH,  c_op_beq,   6'h00,       1'b1, 1'b1);
        plan(ST_DECODE, c_op_beq,   6'h00,       1'b1, 1'b1);
        plan(ST_BRANCH, c_op_beq,   6'h00,       1'b0, 1'b1);
        plan(ST_FETCH,  c_op_lw,    6'h00,       1'b1, 1'b1);
        plan(ST_DECODE, c_op_lw,    6'h00,       1'b1, 1'b1);
        plan(ST_MEM_ADDR, c_op_lw,  6'h00,       1'b1, 1'b1);
        plan(ST_MEM_RD, c_op_lw,    6'h00,       1'b1, 1'b1);
        plan(ST_MEM_WB, c_op_lw,    6'h00,       1'b1, 1'b1);
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL back_to_back c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    task automatic test_reset_mem_wr();
        exp_t e;
        int   n = 0;
        plan(ST_FETCH,    c_op_sw, 6'h00, 1'b1, 1'b1);
        plan(ST_DECODE,   c_op_sw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_ADDR, c_op_sw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_WR,   c_op_sw, 6'h00, 1'b0, 1'b1);
        plan(ST_MEM_WR,   c_op_sw, 6'h00, 1'b0, 1'b0);
        plan(ST_FETCH,    c_op_sw, 6'h00, 1'b0, 1'b1);
        plan(ST_FETCH,    c_op_sw, 6'h00, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL reset_mem_wr c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        int   n = 0;
        plan(ST_FETCH,  6'h3F, 6'h00, 1'b1, 1'b1);
        plan(ST_DECODE, 6'h3F, 6'h00, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            plan(ST_ILLEGAL, 6'h3F, 6'h00, 1'($urandom_range(0, 1)), 1'b1);
        end
        plan(ST_ILLEGAL, 6'h3F, 6'h00, 1'b1, 1'b0);
        plan(ST_FETCH,   6'h00, 6'h00, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            step(e);
            total++;
            if ({state_o, ctl_obs} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL illegal c%0d: got st=%0d ctl=%b want st=%0d ctl=%b",
                         n, state_o, ctl_obs, e.st, e.ctl);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_lw_wait();
        test_sw();
        test_branch_jump();
        test_back_to_back();
        test_reset_mem_wr();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
